reg_dump_reader: RTL

Sequential read-out engine for the 32×32 MIPS register file. On a start pulse it walks register addresses 0..31 through one register-file read port and streams each word, tagged with its address, over a valid/ready output. It sits beside the register file and drives a spare read address, the same A1/A2-style combinational read port. It serves as the synthesizable, run-time counterpart to simulation-only memory dumps, feeding a debug UART or trace buffer.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/reg_dump_reader_if.sv | 32 +++
 rtl/reg_dump_reader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared register-file constants and the dump FSM state type
// Contents:
//   REG_ADDR_W, REG_DATA_W, NUM_REGS : register-file geometry (32 x 32)
//   CHK_ADDR                          : out_addr tag carried by the checksum word
//   dump_state_e                      : reg_dump_reader FSM states; CHK exists only
//                                       when REG_DUMP_CHECKSUM_EN is defined
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] CHK_ADDR = '1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        SEND = 3'd2,
`ifdef REG_DUMP_CHECKSUM_EN
        CHK  = 3'd4,
`endif
        DONE = 3'd3
    } dump_state_e;

endpackage

// File: rtl/reg_dump_reader_if.sv
// rtl/reg_dump_reader_if.sv - valid/ready word stream carrying register value and index
// Signals:
//   out_valid : word present on out_data/out_addr
//   out_ready : consumer accepts the word when high together with out_valid
//   out_data  : register value (or checksum)
//   out_addr  : register index (or CHK_ADDR for the checksum)
// Modports: master (producer, reg_dump_reader), slave (consumer)
interface reg_dump_reader_if
    import mips_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output out_valid,
        output out_data,
        output out_addr,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_addr,
        output out_ready
    );
endinterface

// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - walks register-file addresses 0..NUM_REGS-1 and streams each word
// Ports:
//   clk     : rising-edge clock shared with the register file
//   rst     : synchronous, active-high reset
//   start   : one-cycle dump request, honoured only in IDLE
//   busy    : high while a dump is in progress
//   done    : one-cycle pulse after the final word handshakes
//   rd_addr : address driven to a spare combinational register-file read port
//   rd_data : read data for rd_addr
//   dump    : reg_dump_reader_if.master output stream (out_valid/out_ready/out_data/out_addr)
// Build option: REG_DUMP_CHECKSUM_EN appends an XOR checksum word tagged CHK_ADDR.
module reg_dump_reader
    import mips_pkg::*;
#(
    parameter int NUM_REGS = mips_pkg::NUM_REGS,
    parameter int ADDR_W   = mips_pkg::REG_ADDR_W,
    parameter int DATA_W   = mips_pkg::REG_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic [DATA_W-1:0]    rd_data,
    reg_dump_reader_if.master    dump
);

    dump_state_e       state_q;
    dump_state_e       state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic              last_word;
    logic              handshake;

    assign last_word = (cnt_q == ADDR_W'(NUM_REGS - 1));
    assign handshake = out_valid_q && dump.out_ready;

    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign rd_addr        = cnt_q;
    assign dump.out_valid = out_valid_q;
    assign dump.out_data  = out_data_q;
    assign dump.out_addr  = out_addr_q;

`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] acc_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                end
            end
            READ: begin
                state_d = SEND;
            end
            SEND: begin
                if (handshake) begin
                    if (last_word) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = DONE;
`endif
                    end else begin
                        state_d = READ;
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            CHK: begin
                if (handshake) begin
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Counter returns to 0 on the terminal handshake so rd_addr reads 0
    // again by the time the FSM is back in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
            acc_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
                        acc_q <= '0;
`endif
                    end
                end
                READ: begin
                    out_data_q  <= rd_data;
                    out_addr_q  <= cnt_q;
                    out_valid_q <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                    acc_q       <= acc_q ^ rd_data;
`endif
                end
                SEND: begin
                    if (handshake) begin
                        out_valid_q <= 1'b0;
                        if (last_word) begin
                            cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + ADDR_W'(1);
                        end
                    end
                end
`ifdef REG_DUMP_CHECKSUM_EN
                // First CHK cycle loads the checksum word; it is then held
                // like any data word until the consumer takes it.
                CHK: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= acc_q;
                        out_addr_q  <= CHK_ADDR;
                    end else if (handshake) begin
                        out_valid_q <= 1'b0;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule
